// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// Default dimension limits, FSM state encoding and the op command layout.
package matmul_pkg;

    localparam int MAX_DIM_DEF = 16;
    localparam int MAC_LAT_DEF = 3;

    function automatic int idx_w(input int max_dim);
        return (max_dim > 1) ? $clog2(max_dim) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(MAX_DIM_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] row;
        logic [IDX_W_DEF-1:0] col;
        logic [IDX_W_DEF-1:0] k;
        logic                 first;
        logic                 last;
    } op_cmd_t;

    // A dimension is usable when it is non-zero and fits the index range.
    function automatic logic dim_ok(input logic [31:0] d, input int max_dim);
        return (d != 32'd0) && (d <= unsigned'(max_dim));
    endfunction

endpackage

// File: rtl/nest_cnt3.sv
// Three-level wrap counter (level 0 innermost); advances by one step per enabled cycle.
// No backpressure of its own: en_i is the caller's handshake, last_o flags the final tuple.
module nest_cnt3 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W:0]   lim0_i,
    input  logic [W:0]   lim1_i,
    input  logic [W:0]   lim2_i,
    output logic [W-1:0] cnt0_o,
    output logic [W-1:0] cnt1_o,
    output logic [W-1:0] cnt2_o,
    output logic         last_o
);

    logic [W-1:0] c0_q, c0_d;
    logic [W-1:0] c1_q, c1_d;
    logic [W-1:0] c2_q, c2_d;
    logic         at0, at1, at2;

    // Limits are one bit wider than the counters so a full-range dimension never aliases.
    assign at0 = ({1'b0, c0_q} == lim0_i);
    assign at1 = ({1'b0, c1_q} == lim1_i);
    assign at2 = ({1'b0, c2_q} == lim2_i);

    always_comb begin
        c0_d = c0_q;
        c1_d = c1_q;
        c2_d = c2_q;
        if (clr_i) begin
            c0_d = '0;
            c1_d = '0;
            c2_d = '0;
        end else if (en_i) begin
            if (at0) begin
                c0_d = '0;
                if (at1) begin
                    c1_d = '0;
                    c2_d = at2 ? '0 : c2_q + W'(1);
                end else begin
                    c1_d = c1_q + W'(1);
                end
            end else begin
                c0_d = c0_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
        end else begin
            c0_q <= c0_d;
            c1_q <= c1_d;
            c2_q <= c2_d;
        end
    end

    assign cnt0_o = c0_q;
    assign cnt1_o = c1_q;
    assign cnt2_o = c2_q;
    assign last_o = at0 & at1 & at2;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Matmul sequencer: validates dims on start, issues M*N*K (row,col,k) ops, drains MAC_LAT, pulses done.
// First op valid one cycle after start; op fields hold while op_valid & !op_ready (no retraction).
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter  int MAX_DIM = MAX_DIM_DEF,
    parameter  int MAC_LAT = MAC_LAT_DEF,
    localparam int IDX_W   = idx_w(MAX_DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cfg_m,
    input  logic [31:0]      cfg_k,
    input  logic [31:0]      cfg_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [IDX_W-1:0] op_row,
    output logic [IDX_W-1:0] op_col,
    output logic [IDX_W-1:0] op_k,
    output logic             op_first,
    output logic             op_last
);

    localparam int             DR_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;
    localparam logic [IDX_W:0] ONE  = {{IDX_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic              vld_q, vld_d;
    logic [IDX_W:0]    lim_m_q, lim_m_d;
    logic [IDX_W:0]    lim_k_q, lim_k_d;
    logic [IDX_W:0]    lim_n_q, lim_n_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic              cnt_clr, cnt_en, cnt_last;
    logic [IDX_W-1:0]  idx_row, idx_col, idx_k;
    logic              legal, hs;

    assign legal = dim_ok(cfg_m, MAX_DIM) && dim_ok(cfg_k, MAX_DIM) && dim_ok(cfg_n, MAX_DIM);
    assign hs    = vld_q & op_ready;

    nest_cnt3 #(
        .W(IDX_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .lim0_i (lim_k_q),
        .lim1_i (lim_n_q),
        .lim2_i (lim_m_q),
        .cnt0_o (idx_k),
        .cnt1_o (idx_col),
        .cnt2_o (idx_row),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        vld_d   = vld_q;
        lim_m_d = lim_m_q;
        lim_k_d = lim_k_q;
        lim_n_d = lim_n_q;
        drain_d = drain_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal) begin
                        lim_m_d = cfg_m[IDX_W:0] - ONE;
                        lim_k_d = cfg_k[IDX_W:0] - ONE;
                        lim_n_d = cfg_n[IDX_W:0] - ONE;
                        err_d   = 1'b0;
                        vld_d   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        vld_d = 1'b0;
                        if (MAC_LAT == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            drain_d = DR_W'(MAC_LAT);
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DR_W'(1);
                if (drain_q == DR_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            lim_m_q <= '0;
            lim_k_q <= '0;
            lim_n_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            lim_m_q <= lim_m_d;
            lim_k_q <= lim_k_d;
            lim_n_q <= lim_n_d;
            drain_q <= drain_d;
        end
    end

    // first/last are qualified by valid so they read 0 whenever no command is presented.
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign op_valid = vld_q;
    assign op_row   = idx_row;
    assign op_col   = idx_col;
    assign op_k     = idx_k;
    assign op_first = vld_q && (idx_k == '0);
    assign op_last  = vld_q && ({1'b0, idx_k} == lim_k_q);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: op ordering, stalls, illegal dims, restart and reset abort.
module tb_matmul_seq_ctrl;

    localparam int MAX_DIM = 16;
    localparam int MAC_LAT = 3;
    localparam int IDX_W   = 4;

    logic             clk;
    logic             rst_n;
    logic [31:0]      cfg_m, cfg_k, cfg_n;
    logic             start;
    logic             busy, done, err;
    logic             op_valid, op_ready;
    logic [IDX_W-1:0] op_row, op_col, op_k;
    logic             op_first, op_last;

    int n_chk  = 0;
    int n_pass = 0;

    matmul_seq_ctrl #(
        .MAX_DIM (MAX_DIM),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_m    (cfg_m),
        .cfg_k    (cfg_k),
        .cfg_n    (cfg_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_row   (op_row),
        .op_col   (op_col),
        .op_k     (op_k),
        .op_first (op_first),
        .op_last  (op_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // Advance to 1 time unit after the next rising edge; all sampling and driving happens there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int m, input int k, input int n, input bit rnd, input bit poke);
        int  r, c, kk, nops, total, cyc;
        bit  poked;
        logic rdy;
        r = 0; c = 0; kk = 0; nops = 0; cyc = 0; poked = 0;
        total = m * n * k;
        cfg_m = m; cfg_k = k; cfg_n = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", err, 0);
        chk("busy_run", busy, 1);
        while (nops < total && cyc < 3000) begin
            if (poke) begin
                if (nops == 3 && !poked) begin
                    start = 1'b1;
                    cfg_m = 7; cfg_k = 7; cfg_n = 7;
                    poked = 1;
                end else begin
                    start = 1'b0;
                end
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            op_ready = rdy;
            chk("op_valid", op_valid, 1);
            chk("op_row", op_row, r);
            chk("op_col", op_col, c);
            chk("op_k", op_k, kk);
            chk("op_first", op_first, (kk == 0));
            chk("op_last", op_last, (kk == k - 1));
            if (rdy) begin
                nops++;
                kk++;
                if (kk == k) begin
                    kk = 0;
                    c++;
                    if (c == n) begin
                        c = 0;
                        r++;
                    end
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        op_ready = 1'b0;
        chk("op_count", nops, total);
        for (int d = 0; d < MAC_LAT; d++) begin
            chk("drain_valid", op_valid, 0);
            chk("drain_done", done, 0);
            chk("drain_busy", busy, 1);
            tick();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_err", err, 0);
        tick();
        chk("done_once", done, 0);
        chk("idle_valid", op_valid, 0);
        cfg_m = 0; cfg_k = 0; cfg_n = 0;
    endtask

    task automatic run_bad(input int m, input int k, input int n);
        cfg_m = m; cfg_k = k; cfg_n = n;
        op_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_done", done, 1);
        chk("bad_err", err, 1);
        chk("bad_valid", op_valid, 0);
        chk("bad_busy", busy, 0);
        tick();
        chk("bad_done_once", done, 0);
        chk("bad_err_sticky", err, 1);
        chk("bad_valid2", op_valid, 0);
        op_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_ready = 1'b0;
        cfg_m = 0; cfg_k = 0; cfg_n = 0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_first", op_first, 0);
        chk("rst_last", op_last, 0);
        chk("rst_row", op_row, 0);
        #9 rst_n = 1'b1;
        tick();

        // Basic job, always ready, then the same job with random stalls.
        run_job(2, 3, 2, 1'b0, 1'b0);
        run_job(2, 3, 2, 1'b1, 1'b0);

        // Illegal K, then a legal job clears err.
        run_bad(2, 0, 2);
        tick();
        chk("err_held_idle", err, 1);
        run_job(1, 2, 1, 1'b0, 1'b0);

        // Boundaries.
        run_job(1, 1, 1, 1'b0, 1'b0);
        run_job(MAX_DIM, 1, 1, 1'b1, 1'b0);
        run_bad(MAX_DIM + 1, 1, 1);
        run_bad(1, 1, MAX_DIM + 1);
        run_job(1, MAX_DIM, 2, 1'b0, 1'b0);

        // Restart request and cfg changes mid-run are ignored.
        run_job(2, 3, 2, 1'b1, 1'b1);
        tick();
        chk("poke_no_requeue", busy, 0);

        // Reset abort mid-run.
        cfg_m = 2; cfg_k = 2; cfg_n = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", op_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_row", op_row, 0);
        chk("abort_col", op_col, 0);
        chk("abort_k", op_k, 0);
        chk("abort_first", op_first, 0);
        chk("abort_last", op_last, 0);
        op_ready = 1'b0;
        tick();
        chk("abort_no_done", done, 0);
        rst_n = 1'b1;
        tick();
        run_job(1, 2, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
